// File: rtl/tw12_rot_seq.sv
// Twiddle rotation stage for the 12-point DFT: walks (n*k) mod 12 through the
// twiddle ROM and multiplies each sample by it. Define TW12_CONJ_EN for the IDFT direction.
module tw12_rot_seq #(
    parameter int DW     = 16,
    parameter int N_BINS = 12,
    parameter int TW_LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sop,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    output logic [10:0]          tw_addr,
    input  logic signed [17:0]   tw_re,
    input  logic signed [17:0]   tw_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic [3:0]           out_n,
    output logic [3:0]           out_k,
    output logic                 out_last,
    output logic                 out_flast,
    output logic                 sop_err
);
    localparam int PW = DW + 18;
    localparam int SW = PW + 1;
    localparam logic [3:0] K_LAST = 4'(N_BINS - 1);
    localparam logic signed [SW-1:0] SAT_HI = SW'((1 <<< (DW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = SW'(-(1 <<< (DW - 1)));

    logic stall, accept;
    logic [3:0] cnt_n, cnt_k, acc;
    logic [3:0] smp_n, smp_k, smp_addr, addr_nxt;
    logic [4:0] addr_sum;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;

    always_comb begin
        smp_n    = in_sop ? 4'd0 : cnt_n;
        smp_k    = in_sop ? 4'd0 : cnt_k;
        smp_addr = in_sop ? 4'd0 : acc;
        addr_sum = {1'b0, smp_addr} + {1'b0, smp_k};
        addr_nxt = (addr_sum >= 5'd12) ? 4'(addr_sum - 5'd12) : addr_sum[3:0];
    end

    // acc holds the twiddle address of the next sample of the pass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_n   <= '0;
            cnt_k   <= '0;
            acc     <= '0;
            sop_err <= 1'b0;
        end else begin
            sop_err <= accept && in_sop && (cnt_n != 4'd0 || cnt_k != 4'd0);
            if (accept) begin
                if (smp_n == 4'd11) begin
                    cnt_n <= 4'd0;
                    acc   <= 4'd0;
                    cnt_k <= (smp_k == K_LAST) ? 4'd0 : smp_k + 4'd1;
                end else begin
                    cnt_n <= smp_n + 4'd1;
                    acc   <= addr_nxt;
                    cnt_k <= smp_k;
                end
            end
        end
    end

    logic                 s0_vld;
    logic signed [DW-1:0] s0_re, s0_im;
    logic [3:0]           s0_n, s0_k, s0_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_vld  <= 1'b0;
            s0_re   <= '0;
            s0_im   <= '0;
            s0_n    <= '0;
            s0_k    <= '0;
            s0_addr <= '0;
        end else if (!stall) begin
            s0_vld <= accept;
            if (accept) begin
                s0_re   <= in_re;
                s0_im   <= in_im;
                s0_n    <= smp_n;
                s0_k    <= smp_k;
                s0_addr <= smp_addr;
            end
        end
    end

    assign tw_addr = {7'd0, s0_addr};

    logic                 m_vld;
    logic signed [DW-1:0] m_re, m_im;
    logic [3:0]           m_n, m_k;
    logic signed [17:0]   tw_use_re, tw_use_im, tw_im_eff;

    generate
        if (TW_LAT == 1) begin : g_lat1
            // The ROM keeps re-reading the held address during a stall, so the
            // word that belongs to the delay-stage sample is captured on stall entry.
            logic                 stall_q, d_vld;
            logic signed [17:0]   hold_re, hold_im;
            logic signed [DW-1:0] d_re, d_im;
            logic [3:0]           d_n, d_k;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stall_q <= 1'b0;
                    hold_re <= '0;
                    hold_im <= '0;
                    d_vld   <= 1'b0;
                    d_re    <= '0;
                    d_im    <= '0;
                    d_n     <= '0;
                    d_k     <= '0;
                end else begin
                    stall_q <= stall;
                    if (!stall_q) begin
                        hold_re <= tw_re;
                        hold_im <= tw_im;
                    end
                    if (!stall) begin
                        d_vld <= s0_vld;
                        d_re  <= s0_re;
                        d_im  <= s0_im;
                        d_n   <= s0_n;
                        d_k   <= s0_k;
                    end
                end
            end

            assign m_vld     = d_vld;
            assign m_re      = d_re;
            assign m_im      = d_im;
            assign m_n       = d_n;
            assign m_k       = d_k;
            assign tw_use_re = stall_q ? hold_re : tw_re;
            assign tw_use_im = stall_q ? hold_im : tw_im;
        end else begin : g_lat0
            assign m_vld     = s0_vld;
            assign m_re      = s0_re;
            assign m_im      = s0_im;
            assign m_n       = s0_n;
            assign m_k       = s0_k;
            assign tw_use_re = tw_re;
            assign tw_use_im = tw_im;
        end
    endgenerate

    always_comb begin
`ifdef TW12_CONJ_EN
        tw_im_eff = (tw_use_im == 18'sh20000) ? 18'sh1FFFF : -tw_use_im;
`else
        tw_im_eff = tw_use_im;
`endif
    end

    logic                 s1_vld;
    logic [3:0]           s1_n, s1_k;
    logic signed [PW-1:0] s1_ac, s1_bd, s1_ad, s1_bc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_n   <= '0;
            s1_k   <= '0;
            s1_ac  <= '0;
            s1_bd  <= '0;
            s1_ad  <= '0;
            s1_bc  <= '0;
        end else if (!stall) begin
            s1_vld <= m_vld;
            s1_n   <= m_n;
            s1_k   <= m_k;
            s1_ac  <= PW'(m_re) * PW'(tw_use_re);
            s1_bd  <= PW'(m_im) * PW'(tw_im_eff);
            s1_ad  <= PW'(m_re) * PW'(tw_im_eff);
            s1_bc  <= PW'(m_im) * PW'(tw_use_re);
        end
    end

    function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI) return SAT_HI[DW-1:0];
        if (v < SAT_LO) return SAT_LO[DW-1:0];
        return v[DW-1:0];
    endfunction

    logic signed [SW-1:0] sum_re, sum_im, rnd_re, rnd_im;

    always_comb begin
        sum_re = SW'(s1_ac) - SW'(s1_bd);
        sum_im = SW'(s1_ad) + SW'(s1_bc);
        rnd_re = (sum_re + SW'(512)) >>> 10;
        rnd_im = (sum_im + SW'(512)) >>> 10;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            out_n     <= '0;
            out_k     <= '0;
            out_last  <= 1'b0;
            out_flast <= 1'b0;
        end else if (!stall) begin
            out_valid <= s1_vld;
            out_re    <= sat(rnd_re);
            out_im    <= sat(rnd_im);
            out_n     <= s1_n;
            out_k     <= s1_k;
            out_last  <= (s1_n == 4'd11);
            out_flast <= (s1_n == 4'd11) && (s1_k == K_LAST);
        end
    end
endmodule
